// File: rtl/regwb_queue.sv
// Register-file writeback queue: merges MEM and ALU writeback requests into an
// in-order FIFO drained one write per cycle. Optional bypass search: REGWB_BYPASS_EN.
module regwb_queue #(
    parameter int DEPTH  = 4,
    parameter int WORD_W = 32,
    parameter int REG_W  = 5
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       mem_valid,
    input  logic [REG_W-1:0]           mem_wsel,
    input  logic [WORD_W-1:0]          mem_wdat,
    output logic                       mem_ready,
    input  logic                       alu_valid,
    input  logic [REG_W-1:0]           alu_wsel,
    input  logic [WORD_W-1:0]          alu_wdat,
    output logic                       alu_ready,
    input  logic                       rf_hold,
    output logic                       rf_WEN,
    output logic [REG_W-1:0]           rf_wsel,
    output logic [WORD_W-1:0]          rf_wdat,
    input  logic [REG_W-1:0]           look_sel1,
    input  logic [REG_W-1:0]           look_sel2,
    output logic                       look_hit1,
    output logic                       look_hit2,
    output logic [WORD_W-1:0]          look_dat1,
    output logic [WORD_W-1:0]          look_dat2,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [REG_W-1:0]  wsel_r [DEPTH];
    logic [WORD_W-1:0] dat_r  [DEPTH];
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;

    logic [CNT_W-1:0]  free_s;
    logic              mem_enq_s;
    logic              alu_enq_s;
    logic              drain_s;
    logic [PTR_W-1:0]  alu_idx_s;

    // Space is judged on registered occupancy only, so a same-cycle drain never frees a slot.
    assign free_s    = CNT_W'(DEPTH) - count_r;
    assign mem_ready = (free_s >= CNT_W'(1));
    assign alu_ready = (free_s >= (mem_valid ? CNT_W'(2) : CNT_W'(1)));

    // Register 0 writes are acknowledged but dropped.
    assign mem_enq_s = mem_valid & mem_ready & (mem_wsel != '0);
    assign alu_enq_s = alu_valid & alu_ready & (alu_wsel != '0);
    assign alu_idx_s = tail_r + PTR_W'(mem_enq_s);

    assign drain_s = (count_r != '0) & ~rf_hold;
    assign rf_WEN  = drain_s;
    assign rf_wsel = wsel_r[head_r];
    assign rf_wdat = dat_r[head_r];

    assign count = count_r;
    assign empty = (count_r == '0);
    assign full  = (count_r == CNT_W'(DEPTH));

    // FIFO storage, pointers and occupancy; MEM is older so it takes the tail slot first.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                wsel_r[i] <= '0;
                dat_r[i]  <= '0;
            end
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (mem_enq_s) begin
                wsel_r[tail_r] <= mem_wsel;
                dat_r[tail_r]  <= mem_wdat;
            end
            if (alu_enq_s) begin
                wsel_r[alu_idx_s] <= alu_wsel;
                dat_r[alu_idx_s]  <= alu_wdat;
            end
            head_r  <= head_r + PTR_W'(drain_s);
            tail_r  <= tail_r + PTR_W'(mem_enq_s) + PTR_W'(alu_enq_s);
            count_r <= count_r + CNT_W'(mem_enq_s) + CNT_W'(alu_enq_s) - CNT_W'(drain_s);
        end
    end

`ifdef REGWB_BYPASS_EN
    logic              hit1_s;
    logic              hit2_s;
    logic [WORD_W-1:0] dat1_s;
    logic [WORD_W-1:0] dat2_s;
    logic              m1_s;
    logic              m2_s;

    // Walk occupied entries oldest to newest so the newest match overrides earlier ones.
    always_comb begin
        hit1_s = 1'b0;
        hit2_s = 1'b0;
        dat1_s = '0;
        dat2_s = '0;
        m1_s   = 1'b0;
        m2_s   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            m1_s   = (CNT_W'(i) < count_r) && (look_sel1 != '0) &&
                     (wsel_r[head_r + PTR_W'(i)] == look_sel1);
            m2_s   = (CNT_W'(i) < count_r) && (look_sel2 != '0) &&
                     (wsel_r[head_r + PTR_W'(i)] == look_sel2);
            hit1_s = hit1_s | m1_s;
            hit2_s = hit2_s | m2_s;
            dat1_s = m1_s ? dat_r[head_r + PTR_W'(i)] : dat1_s;
            dat2_s = m2_s ? dat_r[head_r + PTR_W'(i)] : dat2_s;
        end
    end

    assign look_hit1 = hit1_s;
    assign look_hit2 = hit2_s;
    assign look_dat1 = dat1_s;
    assign look_dat2 = dat2_s;
`else
    assign look_hit1 = 1'b0;
    assign look_hit2 = 1'b0;
    assign look_dat1 = '0;
    assign look_dat2 = '0;
`endif

endmodule

// File: tb/tb_regwb_queue.sv
// Scoreboard bench for regwb_queue: expected register-file writes are queued when
// requests are accepted and compared as the queue drains.
module tb_regwb_queue;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        mem_valid = 1'b0, alu_valid = 1'b0, rf_hold = 1'b0;
    logic [4:0]  mem_wsel = 5'd0, alu_wsel = 5'd0, look_sel1 = 5'd0, look_sel2 = 5'd0;
    logic [31:0] mem_wdat = 32'd0, alu_wdat = 32'd0;
    logic        mem_ready, alu_ready, rf_WEN, look_hit1, look_hit2, empty, full;
    logic [4:0]  rf_wsel;
    logic [31:0] rf_wdat, look_dat1, look_dat2;
    logic [2:0]  count;

    typedef struct packed {
        logic [4:0]  sel;
        logic [31:0] dat;
    } wr_t;

    wr_t sb[$];
    wr_t got;
    int  pass_cnt = 0;
    int  total_cnt = 0;

    regwb_queue #(.DEPTH(4), .WORD_W(32), .REG_W(5)) dut (
        .CLK(CLK), .nRST(nRST),
        .mem_valid(mem_valid), .mem_wsel(mem_wsel), .mem_wdat(mem_wdat), .mem_ready(mem_ready),
        .alu_valid(alu_valid), .alu_wsel(alu_wsel), .alu_wdat(alu_wdat), .alu_ready(alu_ready),
        .rf_hold(rf_hold), .rf_WEN(rf_WEN), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat),
        .look_sel1(look_sel1), .look_sel2(look_sel2),
        .look_hit1(look_hit1), .look_hit2(look_hit2),
        .look_dat1(look_dat1), .look_dat2(look_dat2),
        .count(count), .empty(empty), .full(full)
    );

    always #5 CLK = ~CLK;

    // Every register-file write must match the oldest outstanding expected write.
    always @(negedge CLK) begin
        if (nRST && rf_WEN) begin
            total_cnt++;
            if (sb.size() == 0) begin
                $display("FAIL drain_unexpected: wrote r%0d=%h, expected no write", rf_wsel, rf_wdat);
            end else begin
                got = sb.pop_front();
                if ({rf_wsel, rf_wdat} !== {got.sel, got.dat})
                    $display("FAIL drain_order: got r%0d=%h, expected r%0d=%h",
                             rf_wsel, rf_wdat, got.sel, got.dat);
                else
                    pass_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        mem_valid = 1'b0;
        alu_valid = 1'b0;
        mem_wsel  = 5'd0;
        alu_wsel  = 5'd0;
    endtask

    task automatic test_reset();
        #12;
        total_cnt++;
        if ({rf_WEN, empty, full, count, mem_ready, alu_ready, look_hit1, look_hit2} !==
            {1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0})
            $display("FAIL reset_state: wen=%b empty=%b full=%b count=%0d mr=%b ar=%b, expected 0 1 0 0 1 1",
                     rf_WEN, empty, full, count, mem_ready, alu_ready);
        else pass_cnt++;
        total_cnt++;
        if ({look_dat1, look_dat2, rf_wsel, rf_wdat} !== {32'd0, 32'd0, 5'd0, 32'd0})
            $display("FAIL reset_data: look=%h/%h rf=%0d/%h, expected zeros",
                     look_dat1, look_dat2, rf_wsel, rf_wdat);
        else pass_cnt++;
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_dual_order();
        mem_valid = 1'b1; mem_wsel = 5'd3; mem_wdat = 32'hAAAA0001;
        alu_valid = 1'b1; alu_wsel = 5'd4; alu_wdat = 32'h0000BEEF;
        sb.push_back('{5'd3, 32'hAAAA0001});
        sb.push_back('{5'd4, 32'h0000BEEF});
        tick();
        idle();
        total_cnt++;
        if ({rf_WEN, rf_wsel, rf_wdat} !== {1'b1, 5'd3, 32'hAAAA0001})
            $display("FAIL dual_first: wen=%b r%0d=%h, expected 1 r3=aaaa0001", rf_WEN, rf_wsel, rf_wdat);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({rf_WEN, rf_wsel, rf_wdat} !== {1'b1, 5'd4, 32'h0000BEEF})
            $display("FAIL dual_second: wen=%b r%0d=%h, expected 1 r4=0000beef", rf_WEN, rf_wsel, rf_wdat);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({empty, rf_WEN} !== 2'b10)
            $display("FAIL dual_empty: empty=%b wen=%b, expected 1 0", empty, rf_WEN);
        else pass_cnt++;
    endtask

    task automatic test_full();
        rf_hold = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            alu_valid = 1'b1; alu_wsel = 5'(k); alu_wdat = 32'hC000_0000 + 32'(k);
            sb.push_back('{5'(k), 32'hC000_0000 + 32'(k)});
            tick();
        end
        idle();
        alu_valid = 1'b1; alu_wsel = 5'd9;
        #1;
        total_cnt++;
        if ({count, full, alu_ready, rf_WEN} !== {3'd4, 1'b1, 1'b0, 1'b0})
            $display("FAIL full_state: count=%0d full=%b ar=%b wen=%b, expected 4 1 0 0",
                     count, full, alu_ready, rf_WEN);
        else pass_cnt++;
        alu_valid = 1'b0;
        mem_valid = 1'b1; mem_wsel = 5'd9;
        #1;
        total_cnt++;
        if (mem_ready !== 1'b0)
            $display("FAIL full_mem_ready: got %b, expected 0", mem_ready);
        else pass_cnt++;
        idle();
        rf_hold = 1'b0;
        repeat (4) tick();
        total_cnt++;
        if ({empty, count} !== {1'b1, 3'd0})
            $display("FAIL full_drained: empty=%b count=%0d, expected 1 0", empty, count);
        else pass_cnt++;
    endtask

    task automatic test_near_full();
        rf_hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mem_valid = 1'b1; mem_wsel = 5'(10 + k); mem_wdat = 32'hD000_0000 + 32'(k);
            sb.push_back('{5'(10 + k), 32'hD000_0000 + 32'(k)});
            tick();
        end
        rf_hold = 1'b0;
        mem_valid = 1'b1; mem_wsel = 5'd13; mem_wdat = 32'hD000_0013;
        alu_valid = 1'b1; alu_wsel = 5'd14; alu_wdat = 32'hD000_0014;
        #1;
        total_cnt++;
        if ({mem_ready, alu_ready} !== 2'b10)
            $display("FAIL near_full_ready: mr=%b ar=%b, expected 1 0", mem_ready, alu_ready);
        else pass_cnt++;
        sb.push_back('{5'd13, 32'hD000_0013});
        tick();
        idle();
        total_cnt++;
        if (count !== 3'd3)
            $display("FAIL near_full_count: got %0d, expected 3", count);
        else pass_cnt++;
        repeat (3) tick();
        total_cnt++;
        if (empty !== 1'b1)
            $display("FAIL near_full_drain: empty=%b, expected 1", empty);
        else pass_cnt++;
    endtask

    task automatic test_reg_zero();
        alu_valid = 1'b1; alu_wsel = 5'd0; alu_wdat = 32'h12345678;
        #1;
        total_cnt++;
        if (alu_ready !== 1'b1)
            $display("FAIL r0_ready: got %b, expected 1", alu_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({count, rf_WEN} !== {3'd0, 1'b0})
            $display("FAIL r0_dropped: count=%0d wen=%b, expected 0 0", count, rf_WEN);
        else pass_cnt++;
        mem_valid = 1'b1; mem_wsel = 5'd0; mem_wdat = 32'h0BAD0BAD;
        alu_valid = 1'b1; alu_wsel = 5'd6; alu_wdat = 32'h00000066;
        sb.push_back('{5'd6, 32'h00000066});
        tick();
        idle();
        total_cnt++;
        if ({count, rf_WEN, rf_wsel} !== {3'd1, 1'b1, 5'd6})
            $display("FAIL r0_mixed: count=%0d wen=%b sel=%0d, expected 1 1 6", count, rf_WEN, rf_wsel);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_bypass();
        rf_hold = 1'b1;
        alu_valid = 1'b1; alu_wsel = 5'd5; alu_wdat = 32'h11;
        sb.push_back('{5'd5, 32'h11});
        tick();
        mem_valid = 1'b1; mem_wsel = 5'd5; mem_wdat = 32'h22;
        alu_valid = 1'b1; alu_wsel = 5'd7; alu_wdat = 32'h33;
        sb.push_back('{5'd5, 32'h22});
        sb.push_back('{5'd7, 32'h33});
        tick();
        idle();
        look_sel1 = 5'd5; look_sel2 = 5'd0;
        #1;
`ifdef REGWB_BYPASS_EN
        total_cnt++;
        if ({look_hit1, look_dat1, look_hit2, look_dat2} !== {1'b1, 32'h22, 1'b0, 32'h0})
            $display("FAIL bypass_newest: hit1=%b dat1=%h hit2=%b dat2=%h, expected 1 22 0 0",
                     look_hit1, look_dat1, look_hit2, look_dat2);
        else pass_cnt++;
        look_sel2 = 5'd7;
        #1;
        total_cnt++;
        if ({look_hit2, look_dat2} !== {1'b1, 32'h33})
            $display("FAIL bypass_sel2: hit2=%b dat2=%h, expected 1 33", look_hit2, look_dat2);
        else pass_cnt++;
`else
        total_cnt++;
        if ({look_hit1, look_dat1, look_hit2, look_dat2} !== {1'b0, 32'h0, 1'b0, 32'h0})
            $display("FAIL bypass_off: hit1=%b dat1=%h hit2=%b dat2=%h, expected all 0",
                     look_hit1, look_dat1, look_hit2, look_dat2);
        else pass_cnt++;
`endif
        look_sel1 = 5'd0; look_sel2 = 5'd0;
        rf_hold = 1'b0;
        repeat (3) tick();
        total_cnt++;
        if (empty !== 1'b1)
            $display("FAIL bypass_drain: empty=%b, expected 1", empty);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int mc;
        int enq;
        logic exp_mr, exp_ar;
        mc = 0;
        for (int c = 0; c < 60; c++) begin
            mem_valid = 1'($urandom_range(0, 1)); mem_wsel = 5'($urandom_range(0, 7)); mem_wdat = $urandom;
            alu_valid = 1'($urandom_range(0, 1)); alu_wsel = 5'($urandom_range(0, 7)); alu_wdat = $urandom;
            rf_hold   = ($urandom_range(0, 3) == 0);
            #1;
            exp_mr = ((4 - mc) >= 1);
            exp_ar = ((4 - mc) >= (mem_valid ? 2 : 1));
            total_cnt++;
            if ({mem_ready, alu_ready, count} !== {exp_mr, exp_ar, 3'(mc)})
                $display("FAIL b2b_state: cyc %0d mr=%b ar=%b count=%0d, expected %b %b %0d",
                         c, mem_ready, alu_ready, count, exp_mr, exp_ar, mc);
            else pass_cnt++;
            enq = 0;
            if (mem_valid && exp_mr && mem_wsel != 5'd0) begin
                sb.push_back('{mem_wsel, mem_wdat});
                enq++;
            end
            if (alu_valid && exp_ar && alu_wsel != 5'd0) begin
                sb.push_back('{alu_wsel, alu_wdat});
                enq++;
            end
            mc = mc + enq - ((mc != 0 && !rf_hold) ? 1 : 0);
            tick();
        end
        idle();
        rf_hold = 1'b0;
        repeat (6) tick();
        total_cnt++;
        if ({empty, 32'(sb.size())} !== {1'b1, 32'd0})
            $display("FAIL b2b_drain: empty=%b outstanding=%0d, expected 1 0", empty, sb.size());
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        rf_hold = 1'b1;
        alu_valid = 1'b1; alu_wsel = 5'd8; alu_wdat = 32'h88;
        tick();
        alu_wsel = 5'd9; alu_wdat = 32'h99;
        tick();
        idle();
        #2 nRST = 1'b0;
        #1;
        total_cnt++;
        if ({count, empty, full, rf_WEN, rf_wsel} !== {3'd0, 1'b1, 1'b0, 1'b0, 5'd0})
            $display("FAIL async_reset: count=%0d empty=%b full=%b wen=%b sel=%0d, expected 0 1 0 0 0",
                     count, empty, full, rf_WEN, rf_wsel);
        else pass_cnt++;
        nRST = 1'b1;
        rf_hold = 1'b0;
        tick();
        total_cnt++;
        if ({rf_WEN, count} !== {1'b0, 3'd0})
            $display("FAIL async_discard: wen=%b count=%0d, expected 0 0", rf_WEN, count);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_dual_order();
        test_full();
        test_near_full();
        test_reg_zero();
        test_bypass();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
